// File: rtl/shift_reg_seq.sv
// Sequencer that drives an external N-bit shift_reg as a parallel-to-serial converter:
// accepts a word over valid/ready, loads it, then shifts it out LSB-first at CLKS_PER_BIT cycles per bit.
module shift_reg_seq #(
    parameter int   N            = 8,
    parameter int   CLKS_PER_BIT = 4,
    parameter logic FILL         = 1'b0,
    parameter logic IDLE_LVL     = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    input  logic         abort,
    output logic [1:0]   sr_ctrl,
    output logic [N-1:0] sr_d,
    output logic         sr_s_in,
    input  logic         sr_s_out,
    output logic         ser_out,
    output logic         busy,
    output logic         done
);

    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
    localparam logic [DW-1:0] LAST_DIV = DW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] CTRL_HOLD  = 2'b00;
    localparam logic [1:0] CTRL_SHIFT = 2'b01;
    localparam logic [1:0] CTRL_LOAD  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, next_state;
    logic [BW-1:0] bit_cnt, next_bit_cnt;
    logic [DW-1:0] div_cnt, next_div_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else begin
            state   <= next_state;
            bit_cnt <= next_bit_cnt;
            div_cnt <= next_div_cnt;
        end
    end

    assign sr_d    = in_data;
    assign sr_s_in = FILL;

    always_comb begin
        next_state   = state;
        next_bit_cnt = bit_cnt;
        next_div_cnt = div_cnt;
        in_ready     = 1'b0;
        sr_ctrl      = CTRL_HOLD;
        busy         = 1'b0;
        done         = 1'b0;
        ser_out      = IDLE_LVL;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sr_ctrl      = CTRL_LOAD;
                    next_state   = SHIFT;
                    next_bit_cnt = '0;
                    next_div_cnt = '0;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                ser_out = sr_s_out;
                if (abort) begin
                    // Register contents are left behind; the next load overwrites them.
                    next_state   = IDLE;
                    next_bit_cnt = '0;
                    next_div_cnt = '0;
                end else if (div_cnt == LAST_DIV) begin
                    next_div_cnt = '0;
                    if (bit_cnt == LAST_BIT) begin
                        next_state   = DONE;
                        next_bit_cnt = '0;
                    end else begin
                        sr_ctrl      = CTRL_SHIFT;
                        next_bit_cnt = bit_cnt + 1'b1;
                    end
                end else begin
                    next_div_cnt = div_cnt + 1'b1;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state   = IDLE;
                next_bit_cnt = '0;
                next_div_cnt = '0;
            end
        endcase

        // Keep the datapath frozen while reset is held, even on an accept.
        if (rst) begin
            sr_ctrl = CTRL_HOLD;
        end
    end

    a_no_ctrl11: assert property (@(posedge clk) sr_ctrl != 2'b11);
    a_done_after_shift: assert property (@(posedge clk) disable iff (rst) done |-> $past(state) == SHIFT);
    a_ready_in_idle: assert property (@(posedge clk) in_ready |-> state == IDLE);

endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq: models the attached shift_reg and checks
// handshake, serial timing, abort, reset and the single-cycle-per-bit configuration.
module tb_shift_reg_seq;

    localparam int N = 8;
    localparam int C = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with CLKS_PER_BIT = 4
    logic         rst, in_valid, abort, in_ready, ser_out, busy, done;
    logic [7:0]   in_data, sr_d;
    logic [1:0]   sr_ctrl;
    logic         sr_s_in, sr_s_out;
    logic [7:0]   sr_q = 8'h00;

    // Instance with CLKS_PER_BIT = 1
    logic         in_valid1, abort1, in_ready1, ser_out1, busy1, done1;
    logic [7:0]   in_data1, sr_d1;
    logic [1:0]   sr_ctrl1;
    logic         sr_s_in1, sr_s_out1;
    logic [7:0]   sr_q1 = 8'h00;

    shift_reg_seq #(.N(N), .CLKS_PER_BIT(C), .FILL(1'b0), .IDLE_LVL(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .abort(abort), .sr_ctrl(sr_ctrl), .sr_d(sr_d), .sr_s_in(sr_s_in), .sr_s_out(sr_s_out),
        .ser_out(ser_out), .busy(busy), .done(done)
    );

    shift_reg_seq #(.N(N), .CLKS_PER_BIT(1), .FILL(1'b0), .IDLE_LVL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .abort(abort1), .sr_ctrl(sr_ctrl1), .sr_d(sr_d1), .sr_s_in(sr_s_in1), .sr_s_out(sr_s_out1),
        .ser_out(ser_out1), .busy(busy1), .done(done1)
    );

    // Behavioural shift_reg datapaths driven by the sequencers
    always @(posedge clk) begin
        case (sr_ctrl)
            2'b10:   sr_q <= sr_d;
            2'b01:   sr_q <= {sr_s_in, sr_q[7:1]};
            default: sr_q <= sr_q;
        endcase
        case (sr_ctrl1)
            2'b10:   sr_q1 <= sr_d1;
            2'b01:   sr_q1 <= {sr_s_in1, sr_q1[7:1]};
            default: sr_q1 <= sr_q1;
        endcase
    end
    assign sr_s_out  = sr_q[0];
    assign sr_s_out1 = sr_q1[0];

    int testCount = 0;
    int failCount = 0;
    int loadCount = 0;
    int shiftCount = 0;
    int doneCount = 0;

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       a;
        logic       expReady;
        logic [1:0] expCtrl;
        logic       expSer;
        logic       expBusy;
        logic       expDone;
    } vec_t;

    vec_t vecs[$];

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic a, input logic r);
        in_valid = v;
        in_data  = d;
        abort    = a;
        rst      = r;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        testCount++;
        if (act != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Sample on the falling edge and tally datapath commands for the C=4 instance
    task automatic sampleCycle();
        @(negedge clk);
        if (sr_ctrl == 2'b10) loadCount++;
        if (sr_ctrl == 2'b01) shiftCount++;
        if (done) doneCount++;
    endtask

    task automatic advanceCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            sampleCycle();
            advanceCycle();
        end
    endtask

    // One full frame starting with an accept in the current cycle; ends at cycle N*C+2
    task automatic runFrame(input logic [7:0] w, input logic vAfter, input logic [7:0] dAfter, input string tag);
        int loads0, shifts0, dones0;
        loads0  = loadCount;
        shifts0 = shiftCount;
        dones0  = doneCount;
        applyStimulus(1'b1, w, 1'b0, 1'b0);
        sampleCycle();
        checkOutput({tag, " accept in_ready"}, int'(in_ready), 1);
        checkOutput({tag, " accept sr_ctrl"}, int'(sr_ctrl), 2);
        advanceCycle();
        applyStimulus(vAfter, dAfter, 1'b0, 1'b0);
        for (int c = 1; c <= N * C; c++) begin
            sampleCycle();
            checkOutput($sformatf("%s cyc%0d ser_out", tag, c), int'(ser_out), int'(w[(c - 1) / C]));
            advanceCycle();
        end
        sampleCycle();
        checkOutput({tag, " done pulse"}, int'(done), 1);
        checkOutput({tag, " done busy"}, int'(busy), 0);
        checkOutput({tag, " done in_ready"}, int'(in_ready), 0);
        advanceCycle();
        checkOutput({tag, " loads"}, loadCount - loads0, 1);
        checkOutput({tag, " shifts"}, shiftCount - shifts0, 7);
        checkOutput({tag, " dones"}, doneCount - dones0, 1);
    endtask

    initial begin
        int dones0, loads0;
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1);
        in_valid1 = 1'b0;
        in_data1  = 8'h00;
        abort1    = 1'b0;
        advanceCycle();
        advanceCycle();

        // Reset with in_valid high, then a short A5 frame aborted in its first bit period after a shift
        vecs.push_back('{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].d, vecs[i].a, vecs[i].r);
            sampleCycle();
            checkOutput($sformatf("vec%0d in_ready", i), int'(in_ready), int'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d sr_ctrl", i), int'(sr_ctrl), int'(vecs[i].expCtrl));
            checkOutput($sformatf("vec%0d ser_out", i), int'(ser_out), int'(vecs[i].expSer));
            checkOutput($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d done", i), int'(done), int'(vecs[i].expDone));
            advanceCycle();
        end
        checkOutput("table no done", doneCount, 0);

        // Single A5 frame, then ready again at cycle 34
        runFrame(8'hA5, 1'b0, 8'h00, "frameA5");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        sampleCycle();
        checkOutput("frameA5 cyc34 in_ready", int'(in_ready), 1);
        checkOutput("frameA5 cyc34 ser_out idle", int'(ser_out), 1);
        advanceCycle();
        idleCycles(2);

        // Back-to-back: 80 waits on in_valid through the 01 frame and is accepted at cycle 34
        runFrame(8'h01, 1'b1, 8'h80, "b2b01");
        runFrame(8'h80, 1'b0, 8'h00, "b2b80");
        idleCycles(2);

        // Abort at cycle 10, then FF accepted at cycle 11
        dones0 = doneCount;
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        sampleCycle();
        advanceCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            sampleCycle();
            advanceCycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        sampleCycle();
        checkOutput("abort cyc10 sr_ctrl", int'(sr_ctrl), 0);
        checkOutput("abort cyc10 busy", int'(busy), 1);
        advanceCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        checkOutput("abort cyc11 busy", int'(busy), 0);
        checkOutput("abort no done", doneCount - dones0, 0);
        runFrame(8'hFF, 1'b0, 8'h00, "postAbortFF");
        idleCycles(2);

        // Reset at cycle 15 of a 5A frame with a competing in_valid
        dones0 = doneCount;
        loads0 = loadCount;
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        sampleCycle();
        advanceCycle();
        for (int c = 1; c <= 14; c++) begin
            if (c < 5) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            else applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
            sampleCycle();
            if (c == 5) checkOutput("rst5A cyc5 ser_out", int'(ser_out), 1);
            if (c == 14) checkOutput("rst5A cyc14 ser_out", int'(ser_out), 1);
            if (c == 14) checkOutput("rst5A cyc14 in_ready", int'(in_ready), 0);
            advanceCycle();
        end
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
        sampleCycle();
        checkOutput("rst cyc15 sr_ctrl", int'(sr_ctrl), 0);
        advanceCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        sampleCycle();
        checkOutput("rst cyc16 in_ready", int'(in_ready), 1);
        checkOutput("rst cyc16 busy", int'(busy), 0);
        checkOutput("rst cyc16 ser_out", int'(ser_out), 1);
        advanceCycle();
        idleCycles(30);
        checkOutput("rst no done", doneCount - dones0, 0);
        checkOutput("rst single load", loadCount - loads0, 1);

        // One clock per bit: 3C on cycles 1..8, done at 9
        in_valid1 = 1'b1;
        in_data1  = 8'h3C;
        @(negedge clk);
        checkOutput("c1 accept sr_ctrl", int'(sr_ctrl1), 2);
        advanceCycle();
        in_valid1 = 1'b0;
        in_data1  = 8'h00;
        for (int c = 1; c <= N; c++) begin
            @(negedge clk);
            checkOutput($sformatf("c1 cyc%0d ser_out", c), int'(ser_out1), int'(in_data1 == 8'h00 && ((8'h3C >> (c - 1)) & 1) == 1));
            checkOutput($sformatf("c1 cyc%0d done", c), int'(done1), 0);
            advanceCycle();
        end
        @(negedge clk);
        checkOutput("c1 cyc9 done", int'(done1), 1);
        advanceCycle();
        @(negedge clk);
        checkOutput("c1 cyc10 in_ready", int'(in_ready1), 1);
        checkOutput("c1 cyc10 done", int'(done1), 0);
        advanceCycle();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
